// File: rtl/alarm_pkg.sv
// Shared state encoding, field mask and sizing helpers for the alarm ringer.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } alarm_state_e;

    // Packed time word {s1,s10,A,m1,m10,A,h1,h10}; the two A nibbles are separators.
    localparam logic [31:0] FIELD_MASK = 32'hFF0FF0FF;
    localparam logic [3:0]  SEP_NIBBLE = 4'hA;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic logic time_match(input logic [31:0] a, input logic [31:0] b);
        return ((a ^ b) & FIELD_MASK) == 32'd0;
    endfunction

endpackage

// File: rtl/alarm_ringer_if.sv
// Time/control inputs and ring/buzzer outputs between the alarm blocks and the ringer.
interface alarm_ringer_if;

    logic [31:0] Alarm_data;
    logic [31:0] Time_data;
    logic        Tick_1Hz;
    logic        Alarm_en;
    logic        Stop;
    logic        Snooze;
    logic        Ring;
    logic        Snooze_active;
    logic        Buzzer;

    modport master (
        output Alarm_data, Time_data, Tick_1Hz, Alarm_en, Stop, Snooze,
        input  Ring, Snooze_active, Buzzer
    );

    modport slave (
        input  Alarm_data, Time_data, Tick_1Hz, Alarm_en, Stop, Snooze,
        output Ring, Snooze_active, Buzzer
    );

endinterface

// File: rtl/tone_gen.sv
// Square-wave tone source: toggles every HALF enabled cycles, parked low while disabled.
module tone_gen
    import alarm_pkg::*;
#(
    parameter int HALF = 5
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic en,
    output logic tone
);

    localparam int CW = cnt_w(HALF - 1);

    logic [CW-1:0] div_cnt;

    // Held at zero while disabled so each enable starts with a full low half-period.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_cnt <= '0;
            tone    <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            tone    <= 1'b0;
        end else if (div_cnt == CW'(HALF - 1)) begin
            div_cnt <= '0;
            tone    <= ~tone;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alarm_ringer.sv
// Fires on the first cycle the running time matches the alarm time, then runs
// the ring / snooze / stop sequence and drives a gated buzzer tone.
module alarm_ringer
    import alarm_pkg::*;
#(
    parameter int CLK_FREQ       = 50_000_000,
    parameter int TONE_HZ        = 2_000,
    parameter int RING_TIMEOUT_S = 60,
    parameter int SNOOZE_S       = 300,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic           Clk,
    input  logic           Reset_n,
    alarm_ringer_if.slave  bus
);

    localparam int HALF = CLK_FREQ / (2 * TONE_HZ);
    localparam int RW   = cnt_w(RING_TIMEOUT_S - 1);
    localparam int SW   = cnt_w(SNOOZE_S - 1);
    localparam int NW   = cnt_w(MAX_SNOOZE);

    alarm_state_e  state, state_nxt;
    logic [RW-1:0] ring_cnt, ring_cnt_nxt;
    logic [SW-1:0] snz_cnt, snz_cnt_nxt;
    logic [NW-1:0] snz_num, snz_num_nxt;
    logic          beep_on, beep_on_nxt;
    logic          match, match_q, match_rise;
    logic          tone;

    // Only the rising edge fires, so a Stop inside the matching second stays stopped.
    assign match      = time_match(bus.Alarm_data, bus.Time_data);
    assign match_rise = match & ~match_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            ring_cnt <= '0;
            snz_cnt  <= '0;
            snz_num  <= '0;
            beep_on  <= 1'b0;
            match_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ring_cnt <= ring_cnt_nxt;
            snz_cnt  <= snz_cnt_nxt;
            snz_num  <= snz_num_nxt;
            beep_on  <= beep_on_nxt;
            match_q  <= match;
        end
    end

    // Per-cycle priority: Stop, then disarm, then Snooze, then the second tick.
    always_comb begin
        state_nxt    = state;
        ring_cnt_nxt = ring_cnt;
        snz_cnt_nxt  = snz_cnt;
        snz_num_nxt  = snz_num;
        beep_on_nxt  = beep_on;
        case (state)
            IDLE: begin
                if (!bus.Stop && bus.Alarm_en && match_rise) begin
                    state_nxt    = RINGING;
                    ring_cnt_nxt = '0;
                    snz_num_nxt  = '0;
                    beep_on_nxt  = 1'b1;
                end
            end
            RINGING: begin
                if (bus.Stop || !bus.Alarm_en) begin
                    state_nxt = IDLE;
                end else if (bus.Snooze) begin
                    if (snz_num < NW'(MAX_SNOOZE)) begin
                        state_nxt   = SNOOZE;
                        snz_cnt_nxt = '0;
                        snz_num_nxt = snz_num + 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (bus.Tick_1Hz) begin
                    if (ring_cnt == RW'(RING_TIMEOUT_S - 1)) begin
                        state_nxt = IDLE;
                    end else begin
                        ring_cnt_nxt = ring_cnt + 1'b1;
                        beep_on_nxt  = ~beep_on;
                    end
                end
            end
            SNOOZE: begin
                if (bus.Stop || !bus.Alarm_en) begin
                    state_nxt = IDLE;
                end else if (bus.Tick_1Hz) begin
                    if (snz_cnt == SW'(SNOOZE_S - 1)) begin
                        state_nxt    = RINGING;
                        ring_cnt_nxt = '0;
                        beep_on_nxt  = 1'b1;
                    end else begin
                        snz_cnt_nxt = snz_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    tone_gen #(.HALF(HALF)) u_tone (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .en      (state == RINGING),
        .tone    (tone)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bus.Ring          <= 1'b0;
            bus.Snooze_active <= 1'b0;
            bus.Buzzer        <= 1'b0;
        end else begin
            bus.Ring          <= (state == RINGING);
            bus.Snooze_active <= (state == SNOOZE);
            bus.Buzzer        <= tone & beep_on & (state == RINGING);
        end
    end

endmodule

// File: tb/tb_alarm_ringer.sv
// Scoreboarded bench for alarm_ringer: a reference model queues the expected
// outputs each edge, a monitor compares them half a cycle later.
module tb_alarm_ringer;
    import alarm_pkg::*;

    localparam int CLK_FREQ       = 1000;
    localparam int TONE_HZ        = 100;
    localparam int RING_TIMEOUT_S = 4;
    localparam int SNOOZE_S       = 3;
    localparam int MAX_SNOOZE     = 2;
    localparam int HALF           = 5;
    localparam int SEC            = 12;

    logic Clk     = 1'b0;
    logic Reset_n = 1'b0;

    alarm_ringer_if bus ();

    alarm_ringer #(
        .CLK_FREQ       (CLK_FREQ),
        .TONE_HZ        (TONE_HZ),
        .RING_TIMEOUT_S (RING_TIMEOUT_S),
        .SNOOZE_S       (SNOOZE_S),
        .MAX_SNOOZE     (MAX_SNOOZE)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    int    checks = 0;
    int    errors = 0;
    string phase  = "rst";

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack_time(input int h, input int m, input int s,
                                              input logic [3:0] sep);
        return {4'(s % 10), 4'(s / 10), sep, 4'(m % 10), 4'(m / 10), sep,
                4'(h % 10), 4'(h / 10)};
    endfunction

    // Reference model: outputs reflect the state one edge earlier; tone phase is
    // derived from the cycles spent in the current ring.
    alarm_state_e m_st   = IDLE;
    int           m_rs   = 0;
    int           m_ss   = 0;
    int           m_sn   = 0;
    int           m_rc   = 0;
    bit           m_beep = 1'b0;
    bit           m_mq   = 1'b0;
    bit           mt, rise;
    logic [2:0]   expq[$];

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_st = IDLE; m_rs = 0; m_ss = 0; m_sn = 0; m_rc = 0;
            m_beep = 1'b0; m_mq = 1'b0;
            expq.delete();
        end else begin
            mt = (bus.Alarm_data[31:24] == bus.Time_data[31:24]) &&
                 (bus.Alarm_data[19:12] == bus.Time_data[19:12]) &&
                 (bus.Alarm_data[7:0]   == bus.Time_data[7:0]);
            rise = mt && !m_mq;
            m_mq = mt;
            expq.push_back({m_st == RINGING, m_st == SNOOZE,
                            (m_st == RINGING) && m_beep && ((m_rc / HALF) % 2 == 1)});
            case (m_st)
                IDLE: if (bus.Alarm_en && rise && !bus.Stop) begin
                    m_st = RINGING; m_rs = 0; m_sn = 0; m_beep = 1'b1; m_rc = 0;
                end
                RINGING: begin
                    m_rc++;
                    if (bus.Stop || !bus.Alarm_en) m_st = IDLE;
                    else if (bus.Snooze) begin
                        if (m_sn < MAX_SNOOZE) begin m_st = SNOOZE; m_ss = 0; m_sn++; end
                        else m_st = IDLE;
                    end else if (bus.Tick_1Hz) begin
                        if (m_rs == RING_TIMEOUT_S - 1) m_st = IDLE;
                        else begin m_rs++; m_beep = !m_beep; end
                    end
                end
                SNOOZE: begin
                    if (bus.Stop || !bus.Alarm_en) m_st = IDLE;
                    else if (bus.Tick_1Hz) begin
                        if (m_ss == SNOOZE_S - 1) begin
                            m_st = RINGING; m_rs = 0; m_beep = 1'b1; m_rc = 0;
                        end else m_ss++;
                    end
                end
                default: m_st = IDLE;
            endcase
        end
    end

    logic [2:0] exp_o;
    always @(negedge Clk) begin
        if (expq.size() != 0) begin
            exp_o = expq.pop_front();
            chk({phase, "_out"}, {29'd0, bus.Ring, bus.Snooze_active, bus.Buzzer},
                {29'd0, exp_o});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic pulse_stop();
        bus.Stop = 1'b1; cyc(1); bus.Stop = 1'b0;
    endtask

    task automatic pulse_snooze();
        bus.Snooze = 1'b1; cyc(1); bus.Snooze = 1'b0;
    endtask

    // One second of SEC cycles ending in a tick; returns Buzzer-high samples seen.
    task automatic run_sec(output int hi);
        hi = 0;
        for (int i = 0; i < SEC; i++) begin
            bus.Tick_1Hz = (i == SEC - 1);
            @(negedge Clk);
            if (bus.Buzzer) hi++;
        end
        bus.Tick_1Hz = 1'b0;
    endtask

    task automatic trigger(input logic [31:0] t_on, input logic [31:0] t_off);
        bus.Time_data = t_on; cyc(3); bus.Time_data = t_off;
    endtask

    logic [31:0] alarm_t, off_t;
    int          hi [4];
    int          h;

    initial begin
        alarm_t = pack_time(7, 30, 0, SEP_NIBBLE);
        off_t   = pack_time(7, 29, 59, SEP_NIBBLE);
        bus.Alarm_data = alarm_t; bus.Time_data = off_t;
        bus.Tick_1Hz = 1'b0; bus.Alarm_en = 1'b0; bus.Stop = 1'b0; bus.Snooze = 1'b0;
        cyc(3);
        chk("rst_out", {29'd0, bus.Ring, bus.Snooze_active, bus.Buzzer}, 32'd0);
        Reset_n = 1'b1; bus.Alarm_en = 1'b1;
        cyc(3);

        phase = "t1";
        bus.Time_data = alarm_t;
        cyc(1); chk("t1_lat_n",  32'(bus.Ring), 32'd0);
        cyc(1); chk("t1_lat_n1", 32'(bus.Ring), 32'd1);
        bus.Time_data = pack_time(7, 30, 1, SEP_NIBBLE);
        for (int s = 0; s < 4; s++) run_sec(hi[s]);
        chk("t1_beep0",  32'(hi[0]), 32'd5);
        chk("t1_sil1",   32'(hi[1]), 32'd0);
        chk("t1_beep2",  32'(hi[2] != 0), 32'd1);
        chk("t1_sil3",   32'(hi[3]), 32'd0);
        chk("t1_ring_t4", 32'(bus.Ring), 32'd1);
        cyc(1); chk("t1_timeout", 32'(bus.Ring), 32'd0);

        phase = "t2";
        bus.Time_data = off_t; cyc(2);
        bus.Time_data = pack_time(7, 30, 0, 4'h0);
        cyc(2); chk("t2_sep_fire", 32'(bus.Ring), 32'd1);
        pulse_stop(); cyc(1); chk("t2_stop", 32'(bus.Ring), 32'd0);

        phase = "t3";
        bus.Time_data = off_t; cyc(2);
        bus.Time_data = alarm_t; cyc(3);
        chk("t3_ring", 32'(bus.Ring), 32'd1);
        pulse_stop(); cyc(15);
        chk("t3_no_retrig", 32'(bus.Ring), 32'd0);
        bus.Time_data = off_t; cyc(2);

        phase = "t4";
        trigger(alarm_t, off_t);
        for (int k = 0; k < MAX_SNOOZE; k++) begin
            pulse_snooze(); cyc(1);
            chk("t4_snz", {30'd0, bus.Snooze_active, bus.Buzzer}, 32'd2);
            for (int s = 0; s < SNOOZE_S; s++) run_sec(h);
            cyc(1); chk("t4_rering", {30'd0, bus.Ring, bus.Snooze_active}, 32'd2);
        end
        pulse_snooze(); cyc(1);
        chk("t4_max", {30'd0, bus.Ring, bus.Snooze_active}, 32'd0);
        cyc(2);

        phase = "t5";
        trigger(alarm_t, off_t);
        bus.Stop = 1'b1; bus.Snooze = 1'b1; cyc(1); bus.Stop = 1'b0; bus.Snooze = 1'b0;
        cyc(1); chk("t5_stop_snz", {30'd0, bus.Ring, bus.Snooze_active}, 32'd0);
        cyc(2);
        trigger(alarm_t, off_t);
        pulse_snooze(); cyc(2);
        chk("t5_in_snz", 32'(bus.Snooze_active), 32'd1);
        bus.Alarm_en = 1'b0; cyc(2);
        chk("t5_disarm", 32'(bus.Snooze_active), 32'd0);
        bus.Time_data = alarm_t; cyc(5);
        chk("t5_en0_match", 32'(bus.Ring), 32'd0);
        bus.Time_data = off_t; bus.Alarm_en = 1'b1; cyc(2);

        phase = "t6";
        bus.Time_data = alarm_t; cyc(8);
        chk("t6_ringing", 32'(bus.Ring), 32'd1);
        @(posedge Clk); #2 Reset_n = 1'b0;
        #1 chk("t6_async", {29'd0, bus.Ring, bus.Snooze_active, bus.Buzzer}, 32'd0);
        cyc(2); bus.Time_data = off_t; cyc(1);
        Reset_n = 1'b1; cyc(5);
        chk("t6_no_ring", 32'(bus.Ring), 32'd0);
        bus.Time_data = alarm_t; cyc(3);
        chk("t6_rearm", 32'(bus.Ring), 32'd1);
        pulse_stop(); cyc(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
